// File: rtl/serial_paralelo_azul_pkg.sv
// ============================================================================
// Module   : serial_paralelo_azul_pkg
// Brief    : Shared constants and state encoding for the azul serial receiver
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_paralelo_azul_pkg;

  // Idle/alignment symbol, shared with the transmitter's idle insertion.
  localparam logic [7:0] COM_BYTE = 8'hBC;
  localparam int unsigned ALIGN_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_paralelo_azul_com_detect.sv
// ============================================================================
// Module   : serial_paralelo_azul_com_detect
// Brief    : 8-bit comparator flagging the COM idle symbol
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_paralelo_azul_com_detect #(
  parameter logic [7:0] COM_BYTE = serial_paralelo_azul_pkg::COM_BYTE
) (
  input  logic [7:0] byte_i,
  output logic       is_com_o
);

  assign is_com_o = (byte_i == COM_BYTE);

endmodule

`default_nettype wire

// File: rtl/serial_paralelo_azul.sv
// ============================================================================
// Module   : serial_paralelo_azul
// Brief    : Serial-to-parallel receiver with COM-based byte alignment
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_paralelo_azul #(
  parameter logic [7:0]  COM_BYTE    = serial_paralelo_azul_pkg::COM_BYTE,
  parameter int unsigned ALIGN_COUNT = serial_paralelo_azul_pkg::ALIGN_COUNT_DEFAULT
) (
  input  logic       clk32_f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  import serial_paralelo_azul_pkg::*;

  localparam logic [3:0] ALIGN_CNT = 4'(ALIGN_COUNT);

  // Seven history bits suffice: the oldest bit of the window is shifted out
  // on the same edge the new bit arrives.
  logic [6:0] hist_q;
  logic [7:0] next_sr;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       is_com;
  logic       boundary;

  assign next_sr  = {hist_q, data_in};
  assign boundary = (bit_cnt_q == 3'd7);

  serial_paralelo_azul_com_detect #(
    .COM_BYTE (COM_BYTE)
  ) u_com_detect (
    .byte_i   (next_sr),
    .is_com_o (is_com)
  );

  always_ff @(posedge clk32_f or posedge reset) begin
    if (reset) begin
      hist_q    <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      state_q   <= HUNT;
      data_q    <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      hist_q    <= next_sr[6:0];
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    case (state_q)
      HUNT: begin
        valid_d = 1'b0;
        // Sliding compare: any bit position may start a byte.
        if (is_com) begin
          bit_cnt_d = 3'd0;
          com_cnt_d = 4'd1;
          state_d   = ALIGN;
        end
      end
      ALIGN: begin
        valid_d = 1'b0;
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_cnt_q + 4'd1;
            if (com_cnt_q + 4'd1 == ALIGN_CNT) begin
              state_d = LOCKED;
            end
          end else begin
            com_cnt_d = 4'd0;
            state_d   = HUNT;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          data_d   = next_sr;
          valid_d  = !is_com;
          strobe_d = 1'b1;
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = (state_q == LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_serial_paralelo_azul.sv
// ============================================================================
// Module   : tb_serial_paralelo_azul
// Brief    : Directed self-checking bench for the azul serial receiver
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_paralelo_azul;

  localparam logic [7:0] COM = 8'hBC;
  localparam int         NCOM = 4;

  logic       clk32_f = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int checks   = 0;
  int failures = 0;

  serial_paralelo_azul dut (
    .clk32_f     (clk32_f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  always #5 clk32_f = ~clk32_f;

  // Reference model: edges are numbered from reset; once the first COM is
  // seen at edge 'anchor', byte boundaries are every edge t with (t-anchor)%8==0.
  int         m_t, m_anchor, m_coms, m_mode;  // mode 0 hunt, 1 align, 2 locked
  logic [7:0] m_win, m_data;
  logic       m_valid, m_strobe;

  always @(posedge clk32_f or posedge reset) begin
    if (reset) begin
      m_t = 0; m_anchor = 0; m_coms = 0; m_mode = 0;
      m_win = 8'h00; m_data = 8'h00; m_valid = 1'b0; m_strobe = 1'b0;
    end else begin
      m_t      = m_t + 1;
      m_win    = {m_win[6:0], data_in};
      m_strobe = 1'b0;
      if (m_mode == 0) begin
        if (m_win == COM) begin
          m_anchor = m_t; m_coms = 1; m_mode = 1;
        end
      end else if ((m_t - m_anchor) % 8 == 0) begin
        if (m_mode == 1) begin
          if (m_win == COM) begin
            m_coms = m_coms + 1;
            if (m_coms == NCOM) m_mode = 2;
          end else begin
            m_coms = 0; m_mode = 0;
          end
        end else begin
          m_data = m_win; m_valid = (m_win != COM); m_strobe = 1'b1;
        end
      end
    end
  end

  always @(negedge clk32_f) begin
    if (!reset) begin
      checks = checks + 1;
      if (data_out !== m_data || valid_out !== m_valid ||
          byte_strobe !== m_strobe || active !== (m_mode == 2)) begin
        failures = failures + 1;
        $display("FAIL model t=%0d: dut data=%h valid=%b strobe=%b active=%b, want data=%h valid=%b strobe=%b active=%b",
                 m_t, data_out, valid_out, byte_strobe, active,
                 m_data, m_valid, m_strobe, (m_mode == 2));
      end
    end
  end

  // Event capture for the hand-computed expectations.
  int         bits_sent = 0;
  int         rise_bit  = -1;
  logic       act_prev  = 1'b0;
  logic [7:0] cap_data[$];
  logic       cap_valid[$];
  int         cap_bit[$];

  always @(posedge clk32_f) begin
    #1;
    if (!reset) begin
      if (byte_strobe) begin
        cap_data.push_back(data_out);
        cap_valid.push_back(valid_out);
        cap_bit.push_back(bits_sent);
      end
      if (active && !act_prev) rise_bit = bits_sent;
      act_prev = active;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_capture();
    cap_data.delete(); cap_valid.delete(); cap_bit.delete();
    bits_sent = 0; rise_bit = -1; act_prev = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk32_f);
    reset = 1'b1; data_in = 1'b0;
    @(negedge clk32_f);
    reset = 1'b0;
    clear_capture();
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk32_f);
    data_in   = b;
    bits_sent = bits_sent + 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_coms(input int n);
    for (int i = 0; i < n; i++) send_byte(COM);
  endtask

  // Let the last driven bit be sampled and captured.
  task automatic settle();
    @(posedge clk32_f);
    #2;
  endtask

  task automatic chk_cap(input string name, input int idx,
                         input logic [7:0] d, input logic v, input int bit_no);
    if (idx < cap_data.size()) begin
      chk({name, "_data"},  cap_data[idx],  d);
      chk({name, "_valid"}, cap_valid[idx], v);
      chk({name, "_bit"},   cap_bit[idx],   bit_no);
    end else begin
      chk({name, "_present"}, 0, 1);
    end
  endtask

  initial begin
    // Async reset before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("por_data", data_out, 0);
    chk("por_valid", valid_out, 0);
    chk("por_strobe", byte_strobe, 0);
    chk("por_active", active, 0);

    // A: aligned lock, then one data byte.
    do_reset();
    send_coms(4);
    send_byte(8'h5A);
    settle();
    chk("A_rise_bit", rise_bit, 32);
    chk("A_count", cap_data.size(), 1);
    chk_cap("A_5A", 0, 8'h5A, 1'b1, 40);

    // B: lock at a 3-bit offset.
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_coms(4);
    send_byte(8'h12);
    send_byte(8'h34);
    settle();
    chk("B_rise_bit", rise_bit, 35);
    chk("B_count", cap_data.size(), 2);
    chk_cap("B_12", 0, 8'h12, 1'b1, 43);
    chk_cap("B_34", 1, 8'h34, 1'b1, 51);

    // C: COM bytes while locked are reported but not valid.
    do_reset();
    send_coms(4);
    send_byte(COM);
    send_byte(8'hA7);
    send_byte(COM);
    settle();
    chk("C_count", cap_data.size(), 3);
    chk_cap("C_com0", 0, 8'hBC, 1'b0, 40);
    chk_cap("C_a7",   1, 8'hA7, 1'b1, 48);
    chk_cap("C_com1", 2, 8'hBC, 1'b0, 56);

    // D: broken COM run falls back to hunt; later run locks.
    do_reset();
    send_coms(2);
    send_byte(8'h00);
    settle();
    chk("D_active_after_break", active, 0);
    send_coms(4);
    send_byte(8'h33);
    settle();
    chk("D_rise_bit", rise_bit, 56);
    chk("D_count", cap_data.size(), 1);
    chk_cap("D_33", 0, 8'h33, 1'b1, 64);

    // E: async reset mid-byte while locked, then reacquire.
    do_reset();
    send_coms(4);
    send_byte(8'h11);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    settle();
    chk("E_locked", active, 1);
    chk_cap("E_11", 0, 8'h11, 1'b1, 40);
    reset = 1'b1;
    #1;
    chk("E_rst_data", data_out, 0);
    chk("E_rst_valid", valid_out, 0);
    chk("E_rst_strobe", byte_strobe, 0);
    chk("E_rst_active", active, 0);
    @(negedge clk32_f);
    data_in = 1'b0;
    @(negedge clk32_f);
    reset = 1'b0;
    clear_capture();
    send_coms(3);
    send_byte(8'h22);
    settle();
    chk("E_no_strobe", cap_data.size(), 0);
    chk("E_not_active", active, 0);
    send_coms(4);
    send_byte(8'h44);
    settle();
    chk("E_rise_bit", rise_bit, 64);
    chk("E_count", cap_data.size(), 1);
    chk_cap("E_44", 0, 8'h44, 1'b1, 72);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures = failures + 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/serial_paralelo_azul.md
Name: serial_paralelo_azul

Overview:
- Serial-to-parallel receiver at the far end of the azul parallel-to-serial link.
- Samples one bit per clk32_f edge, MSB first, and finds byte alignment by hunting for the idle COM symbol 8'hBC.
- Once locked, outputs each received byte with a valid flag; COM bytes are idle and are not flagged valid.
- Feeds downstream byte-wide logic in place of a clk4_f domain by issuing a byte strobe.

Parameters:
- COM_BYTE, 8'hBC, idle/alignment symbol.
- ALIGN_COUNT, 4, consecutive byte-aligned COMs required to declare lock (range 2..15).

Ports:
- clk32_f  input  1  bit clock; all logic on its rising edge
- reset  input  1  asynchronous, active-high reset
- data_in  input  1  serial bit, MSB of each byte first
- data_out  output  8  last received byte
- valid_out  output  1  high while data_out holds a non-COM byte received in LOCKED
- byte_strobe  output  1  one-cycle pulse on each byte boundary while LOCKED
- active  output  1  high while LOCKED

Behaviour:
- Reset (async, immediate): data_out=0, valid_out=0, byte_strobe=0, active=0.
  - Internally: sr=0, bit_cnt=0, com_cnt=0, state=HUNT.
- Every edge: sr <= {sr[6:0], data_in}; next_sr denotes this new value.
- HUNT:
  - Compare next_sr to COM_BYTE every edge (sliding window).
  - On match: bit_cnt<=0, com_cnt<=1, state<=ALIGN.
- ALIGN:
  - bit_cnt increments mod 8; a boundary is an edge with bit_cnt==7.
  - At a boundary with next_sr==COM_BYTE: com_cnt++.
    - If com_cnt+1==ALIGN_COUNT: state<=LOCKED and active<=1 at that same edge.
  - At a boundary with next_sr!=COM_BYTE: state<=HUNT, com_cnt<=0.
  - No realignment by the sliding compare while in ALIGN.
- LOCKED:
  - bit_cnt continues mod 8.
  - At each boundary, registered at that same edge:
    - data_out<=next_sr
    - valid_out<=(next_sr!=COM_BYTE)
    - byte_strobe<=1
  - Between boundaries: byte_strobe=0; data_out and valid_out hold.
  - Latency: the byte is visible on the edge that samples its LSB.
  - The first output boundary is 8 edges after the locking edge. The locking COM itself is not reported.
  - Lock is retained until reset; no in-band loss detection.
- In HUNT and ALIGN: valid_out=0, byte_strobe=0, data_out holds its last value.
- Reset asserted mid-byte or mid-lock: all state clears immediately. Reacquiring lock needs ALIGN_COUNT fresh COMs.
- Widths:
  - bit_cnt is 3 bits and wraps 7->0 naturally.
  - com_cnt is 4 bits and saturates at ALIGN_COUNT.
- A COM pattern that straddles a boundary during LOCKED is ignored.

Decomposition:
- Shared package holds:
  - COM_BYTE (8'hBC), shared with the transmitter's idle insertion.
  - State encoding HUNT=2'd0, ALIGN=2'd1, LOCKED=2'd2.
  - ALIGN_COUNT default.
- A single flat module is natural. Optional sub-module: com_detect, an 8-bit comparator of next_sr against COM_BYTE.

Test Plan:
- Reset asserted asynchronously between clock edges -> all outputs 0 immediately, without waiting for an edge.
- Stream of 4 COMs (0xBC), bit-aligned, followed by 0x5A -> active rises on the edge sampling the LSB of the 4th COM. 8 edges later: data_out=0x5A, valid_out=1, byte_strobe pulses for exactly one cycle.
- 3 random bits, then 4 COMs, then 0x12, 0x34 -> lock achieved at the 3-bit offset. Outputs 0x12 then 0x34, strobes 8 cycles apart.
- Lock, then COM, 0xA7, COM -> valid_out sequence 0,1,0 on consecutive strobes; data_out=0xBC,0xA7,0xBC.
- 2 COMs, then 0x00, then 4 COMs -> falls back to HUNT after 0x00 (active stays 0). Locks only after the later 4-COM run.
- Reset asserted for 1 cycle mid-byte while LOCKED -> active=0 immediately. No strobes until 4 new aligned COMs are received.
